// File: rtl/sram_scan_master.sv
// rtl/sram_scan_master.sv - parallel SRAM request to GPIO scan-chain initiator
module sram_scan_master #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int WMASK_WIDTH = 4,
  parameter int CLK_DIV     = 2
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [ADDR_WIDTH-1:0]  req_addr,
  input  logic [DATA_WIDTH-1:0]  req_wdata,
  input  logic [WMASK_WIDTH-1:0] req_wmask,
  input  logic                   req_web,
  output logic                   rsp_valid,
  output logic [DATA_WIDTH-1:0]  rsp_rdata,
  output logic                   gpio_clk,
  output logic                   gpio_in,
  output logic                   gpio_scan,
  output logic                   gpio_sram_load,
  output logic                   global_csb,
  input  logic                   gpio_out
);
  localparam int PKT_W = ADDR_WIDTH + DATA_WIDTH + WMASK_WIDTH + 2;
  localparam int RX_W  = DATA_WIDTH + WMASK_WIDTH + 2;
  localparam int CNT_W = $clog2(2 * CLK_DIV);
  localparam int BIT_W = $clog2(PKT_W);

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(2 * CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_RISE   = CNT_W'(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_SAMPLE = CNT_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BITS_PKT   = BIT_W'(PKT_W - 1);
  localparam logic [BIT_W-1:0] BITS_LOAD  = BIT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT_IN,
    S_LOAD,
    S_SHIFT_OUT,
    S_DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [BIT_W-1:0] bits;
  logic [PKT_W-1:0] tx;
  logic [PKT_W-1:0] req_pkt;
  logic [RX_W-1:0]  rx;
  logic             is_read;
  logic             ready_q;
  logic             period_end;
  logic             clk_nxt;

  assign req_pkt    = {req_addr, req_wdata, 1'b0, req_web, req_wmask};
  assign req_ready  = ready_q & ~wb_rst_i;
  assign period_end = (cnt == CNT_LAST);
  assign cnt_nxt    = period_end ? '0 : cnt + CNT_W'(1);
  // gpio_clk is registered from the next phase position so it never glitches
  assign clk_nxt    = (cnt_nxt >= CNT_RISE);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state          <= S_IDLE;
      cnt            <= '0;
      bits           <= '0;
      tx             <= '0;
      rx             <= '0;
      is_read        <= 1'b0;
      ready_q        <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_rdata      <= '0;
      gpio_clk       <= 1'b0;
      gpio_in        <= 1'b0;
      gpio_scan      <= 1'b0;
      gpio_sram_load <= 1'b0;
      global_csb     <= 1'b1;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          ready_q <= 1'b1;
          if (req_valid && req_ready) begin
            ready_q    <= 1'b0;
            state      <= S_SHIFT_IN;
            cnt        <= '0;
            bits       <= '0;
            tx         <= req_pkt << 1;
            gpio_in    <= req_pkt[PKT_W-1];
            gpio_scan  <= 1'b1;
            global_csb <= 1'b0;
            is_read    <= req_web;
          end
        end
        S_SHIFT_IN: begin
          cnt      <= cnt_nxt;
          gpio_clk <= clk_nxt;
          if (period_end) begin
            if (bits == BITS_PKT) begin
              state          <= S_LOAD;
              bits           <= '0;
              gpio_scan      <= 1'b0;
              gpio_in        <= 1'b0;
              gpio_sram_load <= 1'b1;
            end else begin
              bits    <= bits + BIT_W'(1);
              gpio_in <= tx[PKT_W-1];
              tx      <= tx << 1;
            end
          end
        end
        S_LOAD: begin
          cnt      <= cnt_nxt;
          gpio_clk <= clk_nxt;
          if (period_end) begin
            if (bits == BITS_LOAD) begin
              bits           <= '0;
              gpio_sram_load <= 1'b0;
              if (is_read) begin
                state     <= S_SHIFT_OUT;
                gpio_scan <= 1'b1;
              end else begin
                state     <= S_DONE;
                rsp_valid <= 1'b1;
                rsp_rdata <= '0;
              end
            end else begin
              bits <= bits + BIT_W'(1);
            end
          end
        end
        S_SHIFT_OUT: begin
          cnt      <= cnt_nxt;
          gpio_clk <= clk_nxt;
          // sample just before the chip shifts on the coming rising edge
          if (cnt == CNT_SAMPLE) begin
            rx <= {rx[RX_W-2:0], gpio_out};
          end
          if (period_end) begin
            if (bits == BITS_PKT) begin
              state     <= S_DONE;
              gpio_scan <= 1'b0;
              rsp_valid <= 1'b1;
              rsp_rdata <= rx[RX_W-1 -: DATA_WIDTH];
            end else begin
              bits <= bits + BIT_W'(1);
            end
          end
        end
        S_DONE: begin
          state      <= S_IDLE;
          cnt        <= '0;
          gpio_clk   <= 1'b0;
          global_csb <= 1'b1;
          ready_q    <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end
endmodule
